// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS controller: FSM state encodings,
// opcode/funct values, ALU operation codes and datapath mux encodings.
// The jump path is built only when MULTICYCLE_JUMP_EN is defined.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instruction bits [5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUControl encodings
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOp: internal request from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // PCSrc encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALUOp request (and funct for
// R-type execution) onto the 3-bit ALUControl code.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUControl
);

  // Unknown funct codes and the spare ALUOp value fall back to add.
  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  ALUControl = ALU_ADD;
          FN_SUB:  ALUControl = ALU_SUB;
          FN_AND:  ALUControl = ALU_AND;
          FN_OR:   ALUControl = ALU_OR;
          FN_SLT:  ALUControl = ALU_SLT;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for a multicycle MIPS datapath (lw, sw, R-type,
// beq, addi and optionally j). Outputs decode from the state register only,
// except PCEn which also folds in the ALU Zero flag for beq.
// Optional feature: define MULTICYCLE_JUMP_EN to build the j / JEX path;
// otherwise opcode 000010 is ignored like any other illegal opcode.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] alu_op;
  logic       pc_write;
  logic       branch;

  // Next-state selection; unused encodings and illegal opcodes go to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:         state_d = S_JEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // State register; reset wins over any transition, even mid-instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode; everything not named for a state stays 0.
  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REG;
    alu_op   = ALUOP_ADD;
    PCSrc    = PCSRC_ALU;
    pc_write = 1'b0;
    branch   = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        pc_write = 1'b1;
      end
      S_DECODE: ALUSrcB = SRCB_IMMSH2;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_RTYPEEX: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BEQEX: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDIWB: RegWrite = 1'b1;
`ifdef MULTICYCLE_JUMP_EN
      S_JEX: begin
        PCSrc    = PCSRC_JUMP;
        pc_write = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .funct      (funct),
    .ALUOp      (alu_op),
    .ALUControl (ALUControl)
  );

  // Branch is taken only when the subtraction in BEQEX yields zero.
  assign PCEn  = pc_write | (branch & zero);
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instructions followed by a random
// instruction stream, each cycle compared against a reference built from the
// instruction-level state paths and per-state output table.
module tb_multicycle_controller;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       PCEn;
  logic [3:0] state;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .PCSrc      (PCSrc),
    .PCEn       (PCEn),
    .state      (state)
  );

  int errors = 0;
  int checks = 0;

  // Reference: sequence of states an instruction visits.
  int path_q[$];

  task automatic build_path(input logic [5:0] op);
    path_q = {};
    path_q.push_back(0);
    path_q.push_back(1);
    case (op)
      6'b100011: begin path_q.push_back(2); path_q.push_back(3); path_q.push_back(4); end
      6'b101011: begin path_q.push_back(2); path_q.push_back(5); end
      6'b000000: begin path_q.push_back(6); path_q.push_back(7); end
      6'b000100: path_q.push_back(8);
      6'b001000: begin path_q.push_back(9); path_q.push_back(10); end
`ifdef MULTICYCLE_JUMP_EN
      6'b000010: path_q.push_back(11);
`endif
      default: ;
    endcase
  endtask

  function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Reference output table, packed as
  // {IorD,MemWrite,IRWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUControl,PCSrc,PCEn}
  function automatic logic [14:0] exp_out(input int st, input logic [5:0] fn, input logic z);
    logic iord, mw, irw, rw, rd, m2r, sa, pcen;
    logic [1:0] sb, pcs;
    logic [2:0] alu;
    {iord, mw, irw, rw, rd, m2r, sa, pcen} = 8'd0;
    sb = 2'b00; pcs = 2'b00; alu = 3'b010;
    case (st)
      0:  begin irw = 1; sb = 2'b01; pcen = 1; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  iord = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; alu = rtype_alu(fn); end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; alu = 3'b110; pcs = 2'b01; pcen = z; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {iord, mw, irw, rw, rd, m2r, sa, sb, alu, pcs, pcen};
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [14:0] obs_out();
    return {IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
            ALUSrcB, ALUControl, PCSrc, PCEn};
  endfunction

  // One cycle: drive zero, compare on the falling edge, advance a cycle.
  // zmode 0/1 forces zero, 2 randomizes it.
  task automatic step(input int st, input int zmode, input string tag);
    zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    @(negedge clk);
    check({tag, "_state"}, 15'(state), 15'(st));
    check({tag, "_outs"}, obs_out(), exp_out(st, funct, zero));
    check({tag, "_strobes"}, 15'($countones({MemWrite, IRWrite, RegWrite}) <= 1), 15'd1);
    @(posedge clk);
    #1;
  endtask

  // driver: run one instruction; abort_at >= 0 asserts reset in that step.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int abort_at, input string tag);
    opcode = op;
    funct  = fn;
    build_path(op);
    foreach (path_q[i]) begin
      if (i == abort_at) begin
        zero = 1'b0;
        @(negedge clk);
        check({tag, "_pre_reset_state"}, 15'(state), 15'(path_q[i]));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check({tag, "_reset_state"}, 15'(state), 15'd0);
        check({tag, "_reset_memwrite"}, 15'(MemWrite), 15'd0);
        check({tag, "_reset_regwrite"}, 15'(RegWrite), 15'd0);
        @(posedge clk);
        #1;
        // Instruction was squashed; FETCH has already run, so finish through DECODE
        // with an illegal opcode to return to FETCH cleanly.
        opcode = 6'b111111;
        step(1, 2, {tag, "_after_reset"});
        return;
      end
      step(path_q[i], zmode, tag);
    end
  endtask

  initial begin
    logic [5:0] op_tbl [8];
    logic [5:0] fn_tbl [6];
    op_tbl = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
               6'b001000, 6'b000010, 6'b111111, 6'b010101};
    fn_tbl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

    // Reset held for two edges, then released.
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", 15'(state), 15'd0);
    check("reset_irwrite", 15'(IRWrite), 15'd1);
    check("reset_pcen", 15'(PCEn), 15'd1);
    check("reset_alusrcb", 15'(ALUSrcB), 15'b01);
    @(posedge clk);
    #1;
    // First instruction after reset starts from DECODE (FETCH already used).
    opcode = 6'b111111;
    step(1, 2, "post_reset_decode");

    // Directed instructions
    run_instr(6'b100011, 6'd0, 2, -1, "lw");
    run_instr(6'b101011, 6'd0, 2, -1, "sw");
    run_instr(6'b000000, 6'b100010, 2, -1, "r_sub");
    run_instr(6'b000000, 6'b101010, 2, -1, "r_slt");
    run_instr(6'b000000, 6'b100000, 2, -1, "r_add");
    run_instr(6'b000000, 6'b100100, 2, -1, "r_and");
    run_instr(6'b000000, 6'b100101, 2, -1, "r_or");
    run_instr(6'b000000, 6'b111111, 2, -1, "r_unknown");
    run_instr(6'b000100, 6'd0, 1, -1, "beq_taken");
    run_instr(6'b000100, 6'd0, 0, -1, "beq_not_taken");
    run_instr(6'b001000, 6'd0, 2, -1, "addi");
    run_instr(6'b000010, 6'd0, 2, -1, "jump");
    run_instr(6'b111111, 6'd0, 2, -1, "illegal");
    run_instr(6'b100011, 6'd0, 2, 3, "lw_reset_memrd");

    // Random instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tbl[$urandom_range(0, 7)];
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fn_tbl[$urandom_range(0, 5)];
      run_instr(op, fn, 2, -1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
